// File: rtl/op_encoder.sv
// Builds 3-byte {opcode,data1,data2} host ops from sound, keyboard and mouse slots via a fixed-priority arbiter.
// One clock from request capture to op_valid; op is held until op_ready, then a GAP_CYCLES idle gap is enforced.
module op_encoder #(
  parameter logic [7:0] SND_OP     = 8'h0F,
  parameter logic [7:0] KBD_OP     = 8'hC6,
  parameter logic [7:0] MOUSE_OP   = 8'hC8,
  parameter int         GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        snd_req,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_data,
  input  logic        mouse_valid,
  input  logic [7:0]  mouse_dx,
  input  logic [7:0]  mouse_dy,
  input  logic        ovf_clear,
  output logic [23:0] op,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        kbd_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q, state_d;
  logic        snd_full;
  logic        kbd_full;
  logic [15:0] kbd_buf;
  logic        mouse_full;
  logic [7:0]  dx_acc, dy_acc;
  logic [7:0]  gap_cnt;
  logic        load_snd, load_kbd, load_mouse, load_any, handshake;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    load_snd   = 1'b0;
    load_kbd   = 1'b0;
    load_mouse = 1'b0;
    handshake  = 1'b0;
    case (state_q)
      IDLE: begin
        if (snd_full) begin
          load_snd = 1'b1;
          state_d  = SEND;
        end else if (kbd_full) begin
          load_kbd = 1'b1;
          state_d  = SEND;
        end else if (mouse_full) begin
          load_mouse = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (op_ready) begin
          handshake = 1'b1;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_any = load_snd | load_kbd | load_mouse;
  assign busy     = snd_full | kbd_full | mouse_full | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      op           <= 24'h0;
      op_valid     <= 1'b0;
      gap_cnt      <= 8'd0;
      snd_full     <= 1'b0;
      kbd_full     <= 1'b0;
      kbd_buf      <= 16'h0;
      kbd_overflow <= 1'b0;
      mouse_full   <= 1'b0;
      dx_acc       <= 8'h0;
      dy_acc       <= 8'h0;
    end else begin
      state_q <= state_d;

      if (load_snd)        op <= {SND_OP, 16'h0000};
      else if (load_kbd)   op <= {KBD_OP, kbd_buf};
      else if (load_mouse) op <= {MOUSE_OP, dx_acc, dy_acc};

      if (load_any)       op_valid <= 1'b1;
      else if (handshake) op_valid <= 1'b0;

      if (handshake)             gap_cnt <= 8'(GAP_CYCLES);
      else if (state_q == GAP)   gap_cnt <= gap_cnt - 8'd1;

      if (snd_req)       snd_full <= 1'b1;
      else if (load_snd) snd_full <= 1'b0;

      // A slot being loaded this cycle is free, so a new request refills it rather than dropping/summing.
      if (kbd_valid) begin
        if (kbd_full && !load_kbd) begin
          kbd_overflow <= 1'b1;
        end else begin
          kbd_buf  <= kbd_data;
          kbd_full <= 1'b1;
        end
      end else if (load_kbd) begin
        kbd_full <= 1'b0;
      end
      if (ovf_clear && !(kbd_valid && kbd_full && !load_kbd)) kbd_overflow <= 1'b0;

      if (mouse_valid) begin
        if (mouse_full && !load_mouse) begin
          dx_acc <= sat_add(dx_acc, mouse_dx);
          dy_acc <= sat_add(dy_acc, mouse_dy);
        end else begin
          dx_acc     <= mouse_dx;
          dy_acc     <= mouse_dy;
          mouse_full <= 1'b1;
        end
      end else if (load_mouse) begin
        mouse_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_op_encoder.sv
// Directed bench for op_encoder: a GAP_CYCLES=4 instance and a GAP_CYCLES=0 instance on shared inputs.
module tb_op_encoder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        snd_req, kbd_valid, mouse_valid, ovf_clear, op_ready;
  logic [15:0] kbd_data;
  logic [7:0]  mouse_dx, mouse_dy;
  logic [23:0] op, op0;
  logic        op_valid, op_valid0, kbd_overflow, kbd_overflow0, busy, busy0;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] got_op [4];
  int          got_gap [4];

  always #5 clk = ~clk;

  op_encoder dut (
    .clk(clk), .n_reset(n_reset), .snd_req(snd_req), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .mouse_valid(mouse_valid), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .ovf_clear(ovf_clear),
    .op(op), .op_valid(op_valid), .op_ready(op_ready), .kbd_overflow(kbd_overflow), .busy(busy)
  );

  op_encoder #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .n_reset(n_reset), .snd_req(snd_req), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .mouse_valid(mouse_valid), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .ovf_clear(ovf_clear),
    .op(op0), .op_valid(op_valid0), .op_ready(op_ready), .kbd_overflow(kbd_overflow0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  // Records each op seen valid (op_ready held high) and the op_valid-low samples preceding it.
  task automatic collect(input int n, input bit sel);
    int k, low, cyc;
    k = 0; low = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      if (sel ? op_valid0 : op_valid) begin
        got_op[k]  = sel ? op0 : op;
        got_gap[k] = low;
        k++;
        low = 0;
      end else begin
        low++;
      end
      tick();
      cyc++;
    end
    chk("collect_count", k, n);
  endtask

  initial begin
    n_reset = 1'b0; snd_req = 1'b0; kbd_valid = 1'b0; mouse_valid = 1'b0; ovf_clear = 1'b0;
    op_ready = 1'b0; kbd_data = 16'h0; mouse_dx = 8'h0; mouse_dy = 8'h0;
    tick(); tick();
    chk("rst_op", op, 24'h0);
    chk("rst_valid", op_valid, 1'b0);
    chk("rst_ovf", kbd_overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    n_reset = 1'b1;

    // Single keyboard op, then the enforced gap
    op_ready = 1'b1; kbd_valid = 1'b1; kbd_data = 16'h1234;
    tick();
    kbd_valid = 1'b0;
    chk("kbd_cap_valid", op_valid, 1'b0);
    chk("kbd_cap_busy", busy, 1'b1);
    tick();
    chk("kbd_op_valid", op_valid, 1'b1);
    chk("kbd_op", op, 24'hC61234);
    tick();
    chk("gap_valid0", op_valid, 1'b0);
    chk("gap_busy0", busy, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("gap_valid", op_valid, 1'b0);
      chk("gap_busy", busy, 1'b1);
    end
    tick();
    chk("gap_done_busy", busy, 1'b0);

    // Three sources in the same cycle: priority order and gaps
    op_ready = 1'b0; snd_req = 1'b1; kbd_valid = 1'b1; kbd_data = 16'hABCD;
    mouse_valid = 1'b1; mouse_dx = 8'h05; mouse_dy = 8'hFB;
    tick();
    snd_req = 1'b0; kbd_valid = 1'b0; mouse_valid = 1'b0;
    tick();
    op_ready = 1'b1;
    collect(3, 1'b0);
    chk("prio_op0", got_op[0], 24'h0F0000);
    chk("prio_op1", got_op[1], 24'hC6ABCD);
    chk("prio_op2", got_op[2], 24'hC805FB);
    chk("prio_gap1", got_gap[1], 5);
    chk("prio_gap2", got_gap[2], 5);
    settle();

    // Positive saturation while a kbd op is held, plus 10-cycle hold check
    op_ready = 1'b0; kbd_valid = 1'b1; kbd_data = 16'h1111;
    tick();
    kbd_valid = 1'b0;
    tick();
    mouse_valid = 1'b1; mouse_dx = 8'h64; mouse_dy = 8'h01;
    tick();
    mouse_dy = 8'h02;
    tick();
    mouse_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_op", op, 24'hC61111);
      chk("hold_valid", op_valid, 1'b1);
      tick();
    end
    op_ready = 1'b1;
    collect(2, 1'b0);
    chk("satp_op0", got_op[0], 24'hC61111);
    chk("satp_op1", got_op[1], 24'hC87F03);
    settle();

    // Negative saturation on both axes
    op_ready = 1'b0; kbd_valid = 1'b1; kbd_data = 16'h2222;
    tick();
    kbd_valid = 1'b0;
    tick();
    mouse_valid = 1'b1; mouse_dx = 8'h9C; mouse_dy = 8'h80;
    tick();
    tick();
    mouse_valid = 1'b0;
    op_ready = 1'b1;
    collect(2, 1'b0);
    chk("satn_op0", got_op[0], 24'hC62222);
    chk("satn_op1", got_op[1], 24'hC88080);
    settle();

    // Keyboard overflow, clear, and set-beats-clear
    op_ready = 1'b0; snd_req = 1'b1;
    tick();
    snd_req = 1'b0;
    tick();
    kbd_valid = 1'b1; kbd_data = 16'h5555;
    tick();
    chk("ovf_before", kbd_overflow, 1'b0);
    kbd_data = 16'h6666;
    tick();
    kbd_valid = 1'b0;
    chk("ovf_set", kbd_overflow, 1'b1);
    ovf_clear = 1'b1;
    tick();
    chk("ovf_clr", kbd_overflow, 1'b0);
    kbd_valid = 1'b1; kbd_data = 16'h7777;
    tick();
    kbd_valid = 1'b0;
    chk("ovf_set_wins", kbd_overflow, 1'b1);
    tick();
    ovf_clear = 1'b0;
    chk("ovf_clr2", kbd_overflow, 1'b0);
    op_ready = 1'b1;
    collect(2, 1'b0);
    chk("ovf_op0", got_op[0], 24'h0F0000);
    chk("ovf_op1", got_op[1], 24'hC65555);
    settle();

    // Reset mid-SEND discards the held op and queued slots
    op_ready = 1'b0; kbd_valid = 1'b1; kbd_data = 16'h9999;
    tick();
    kbd_valid = 1'b0;
    tick();
    chk("pre_rst_valid", op_valid, 1'b1);
    snd_req = 1'b1; mouse_valid = 1'b1; mouse_dx = 8'h11; mouse_dy = 8'h22;
    tick();
    snd_req = 1'b0; mouse_valid = 1'b0; n_reset = 1'b0;
    tick();
    chk("mrst_valid", op_valid, 1'b0);
    chk("mrst_op", op, 24'h0);
    chk("mrst_busy", busy, 1'b0);
    n_reset = 1'b1; op_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (op_valid) seen++;
      end
      chk("mrst_no_ops", seen, 0);
    end

    // Zero-gap instance: back-to-back with one load cycle between
    op_ready = 1'b0; snd_req = 1'b1; kbd_valid = 1'b1; kbd_data = 16'h4242;
    mouse_valid = 1'b1; mouse_dx = 8'h01; mouse_dy = 8'h02;
    tick();
    snd_req = 1'b0; kbd_valid = 1'b0; mouse_valid = 1'b0;
    op_ready = 1'b1;
    collect(3, 1'b1);
    chk("g0_op0", got_op[0], 24'h0F0000);
    chk("g0_op1", got_op[1], 24'hC64242);
    chk("g0_op2", got_op[2], 24'hC80102);
    chk("g0_gap1", got_gap[1], 1);
    chk("g0_gap2", got_gap[2], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
